// File: rtl/axi_single_beat_to_mem.sv
// Single-beat AXI4 slave that terminates AW/W/AR onto one SRAM-style request/grant port.
// Reads are credit-limited so the response buffer can never overflow while R is stalled.
module axi_single_beat_to_mem #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned RspDepth  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [IdWidth-1:0]     ar_id_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [IdWidth-1:0]     r_id_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_last_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_strb_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_err_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = $clog2(RspDepth + 1);
    localparam int unsigned PtrWidth  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    localparam logic [CntWidth-1:0] CreditMax = CntWidth'(RspDepth);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
    localparam logic [PtrWidth-1:0] PtrLast   = PtrWidth'(RspDepth - 1);
    localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);

    localparam logic PRIO_WRITE = 1'b0;
    localparam logic PRIO_READ  = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                 prio_q;
    logic                 wr_elig;
    logic                 rd_elig;
    logic                 sel_write;
    logic                 sel_read;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 contested;

    logic                 b_valid_q;
    logic [IdWidth-1:0]   b_id_q;

    logic                 inflight_q;
    logic [IdWidth-1:0]   inflight_id_q;
    logic [CntWidth-1:0]  credits_q;

    logic [IdWidth-1:0]   fifo_id   [RspDepth];
    logic [DataWidth-1:0] fifo_data [RspDepth];
    logic                 fifo_err  [RspDepth];
    logic [PtrWidth-1:0]  wr_ptr_q;
    logic [PtrWidth-1:0]  rd_ptr_q;
    logic [CntWidth-1:0]  count_q;
    logic                 r_push;
    logic                 r_pop;

    // Eligibility is masked by reset so no ready or request can pulse while rst_i is high.
    always_comb begin
        wr_elig   = !rst_i && aw_valid_i && w_valid_i && (!b_valid_q || b_ready_i);
        rd_elig   = !rst_i && ar_valid_i && (credits_q != '0);
        sel_write = wr_elig && (!rd_elig || (prio_q == PRIO_WRITE));
        sel_read  = rd_elig && !sel_write;
        contested = wr_elig && rd_elig;
    end

    assign wr_fire = sel_write && mem_gnt_i;
    assign rd_fire = sel_read && mem_gnt_i;

    assign aw_ready_o = wr_fire;
    assign w_ready_o  = wr_fire;
    assign ar_ready_o = rd_fire;

    always_comb begin
        mem_req_o   = sel_write || sel_read;
        mem_we_o    = sel_write;
        mem_addr_o  = sel_write ? aw_addr_i : ar_addr_i;
        mem_wdata_o = sel_write ? w_data_i : '0;
        mem_strb_o  = sel_write ? w_strb_i : {StrbWidth{1'b1}};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= PRIO_WRITE;
        end else if (contested && mem_gnt_i) begin
            prio_q <= sel_write ? PRIO_READ : PRIO_WRITE;
        end
    end

    // A new write may refill the slot in the same cycle the previous response drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            b_valid_q <= 1'b0;
            b_id_q    <= '0;
        end else if (wr_fire) begin
            b_valid_q <= 1'b1;
            b_id_q    <= aw_id_i;
        end else if (b_ready_i) begin
            b_valid_q <= 1'b0;
        end
    end

    assign b_valid_o = b_valid_q;
    assign b_id_o    = b_id_q;
    assign b_resp_o  = RESP_OKAY;

    // Memory answers exactly one cycle after a grant, so a single ID register covers back-to-back reads.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            inflight_q <= rd_fire;
            if (rd_fire) begin
                inflight_id_q <= ar_id_i;
            end
        end
    end

    assign r_push = mem_rvalid_i;
    assign r_pop  = r_valid_o && r_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credits_q <= CreditMax;
        end else begin
            case ({rd_fire, r_pop})
                2'b10:   credits_q <= credits_q - CntOne;
                2'b01:   credits_q <= credits_q + CntOne;
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_push) begin
            fifo_id[wr_ptr_q]   <= inflight_id_q;
            fifo_data[wr_ptr_q] <= mem_rdata_i;
            fifo_err[wr_ptr_q]  <= mem_err_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (r_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
            end
            if (r_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
            end
            case ({r_push, r_pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    assign r_valid_o = (count_q != '0);
    assign r_id_o    = fifo_id[rd_ptr_q];
    assign r_data_o  = fifo_data[rd_ptr_q];
    assign r_resp_o  = fifo_err[rd_ptr_q] ? RESP_SLVERR : RESP_OKAY;
    assign r_last_o  = 1'b1;

    rvalid_needs_read: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> inflight_q);

    fifo_never_overflows: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> ((count_q != CreditMax) || r_pop));

endmodule

// File: tb/tb_axi_single_beat_to_mem.sv
// Scoreboard bench for axi_single_beat_to_mem: B/R expectations are queued at handshake
// time and checked when the responses appear; a small SRAM model answers memory reads.
module tb_axi_single_beat_to_mem;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        aw_valid_i = 1'b0;
    logic        aw_ready_o;
    logic [3:0]  aw_id_i = '0;
    logic [31:0] aw_addr_i = '0;
    logic        w_valid_i = 1'b0;
    logic        w_ready_o;
    logic [31:0] w_data_i = '0;
    logic [3:0]  w_strb_i = '0;
    logic        b_valid_o;
    logic        b_ready_i = 1'b1;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i = 1'b0;
    logic        ar_ready_o;
    logic [3:0]  ar_id_i = '0;
    logic [31:0] ar_addr_i = '0;
    logic        r_valid_o;
    logic        r_ready_i = 1'b1;
    logic [3:0]  r_id_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b1;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_strb_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;

    logic [3:0]  exp_b [$];
    r_exp_t      exp_r [$];
    logic [31:0] mem_model [logic [31:0]];

    axi_single_beat_to_mem #(
        .AddrWidth(32),
        .DataWidth(32),
        .IdWidth(4),
        .RspDepth(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM model: writes land at the grant, reads answer one cycle later; address 0xBAD0 errors.
    always begin : sram_model
        logic        rd_fire;
        logic [31:0] rd_addr;
        logic [31:0] word;
        @(negedge clk_i);
        rd_fire = !rst_i && mem_req_o && mem_gnt_i && !mem_we_o;
        rd_addr = mem_addr_o;
        if (!rst_i && mem_req_o && mem_gnt_i && mem_we_o) begin
            wr_count++;
            word = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : '0;
            for (int b = 0; b < 4; b++) begin
                if (mem_strb_o[b]) word[8*b +: 8] = mem_wdata_o[8*b +: 8];
            end
            mem_model[mem_addr_o] = word;
        end
        @(posedge clk_i);
        #1;
        mem_rvalid_i = rd_fire;
        mem_rdata_i  = (rd_fire && mem_model.exists(rd_addr)) ? mem_model[rd_addr] : '0;
        mem_err_i    = rd_fire && (rd_addr == 32'hBAD0);
    end

    always @(negedge clk_i) begin : scoreboard
        logic [3:0] eb;
        r_exp_t     er;
        if (!rst_i && b_valid_o && b_ready_i) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL b_unexpected: got id=%0d, required no response", b_id_o);
            end else begin
                eb = exp_b.pop_front();
                if (b_id_o !== eb || b_resp_o !== 2'b00) begin
                    fails++;
                    $display("FAIL b_beat: got id=%0d resp=%b, required id=%0d resp=00", b_id_o, b_resp_o, eb);
                end
            end
        end
        if (!rst_i && r_valid_o && r_ready_i) begin
            tests++;
            if (exp_r.size() == 0) begin
                fails++;
                $display("FAIL r_unexpected: got id=%0d data=%h, required no beat", r_id_o, r_data_o);
            end else begin
                er = exp_r.pop_front();
                if (r_id_o !== er.id || r_data_o !== er.data || r_resp_o !== er.resp || r_last_o !== 1'b1) begin
                    fails++;
                    $display("FAIL r_beat: got id=%0d data=%h resp=%b last=%b, required id=%0d data=%h resp=%b last=1",
                             r_id_o, r_data_o, r_resp_o, r_last_o, er.id, er.data, er.resp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        #3;
        tests++;
        if ({aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o, mem_req_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required 000000",
                     {aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o, mem_req_o});
        end
        tests++;
        if (r_last_o !== 1'b1 || b_resp_o !== 2'b00) begin
            fails++;
            $display("FAIL reset_consts: got last=%b bresp=%b, required last=1 bresp=00", r_last_o, b_resp_o);
        end
        step();
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_write();
        aw_valid_i = 1'b1; aw_addr_i = 32'h10; aw_id_i = 4'd3;
        w_valid_i = 1'b1; w_data_i = 32'hDEADBEEF; w_strb_i = 4'hF;
        exp_b.push_back(4'd3);
        @(negedge clk_i);
        tests++;
        if ({mem_req_o, mem_we_o, aw_ready_o, w_ready_o, ar_ready_o} !== 5'b11110) begin
            fails++;
            $display("FAIL write_grant: got req/we/awr/wr/arr=%b, required 11110",
                     {mem_req_o, mem_we_o, aw_ready_o, w_ready_o, ar_ready_o});
        end
        tests++;
        if (mem_addr_o !== 32'h10 || mem_wdata_o !== 32'hDEADBEEF || mem_strb_o !== 4'hF) begin
            fails++;
            $display("FAIL write_fields: got addr=%h data=%h strb=%h, required 10 deadbeef f",
                     mem_addr_o, mem_wdata_o, mem_strb_o);
        end
        step();
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (b_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL b_latency: got b_valid=%b, required 1", b_valid_o);
        end
        step();
        @(negedge clk_i);
        tests++;
        if (b_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL b_clear: got b_valid=%b, required 0", b_valid_o);
        end
        step();
    endtask

    task automatic test_write_waits_for_w();
        int w0;
        w0 = wr_count;
        aw_valid_i = 1'b1; aw_addr_i = 32'h20; aw_id_i = 4'd7; w_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            tests++;
            if ({mem_req_o, aw_ready_o, w_ready_o} !== 3'b000) begin
                fails++;
                $display("FAIL aw_without_w cycle %0d: got req/awr/wr=%b, required 000", i,
                         {mem_req_o, aw_ready_o, w_ready_o});
            end
            step();
        end
        w_valid_i = 1'b1; w_data_i = 32'h12345678; w_strb_i = 4'b0011; mem_gnt_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({mem_req_o, mem_we_o, aw_ready_o, w_ready_o} !== 4'b1100) begin
            fails++;
            $display("FAIL no_grant: got req/we/awr/wr=%b, required 1100",
                     {mem_req_o, mem_we_o, aw_ready_o, w_ready_o});
        end
        step();
        mem_gnt_i = 1'b1;
        exp_b.push_back(4'd7);
        @(negedge clk_i);
        tests++;
        if ({mem_req_o, mem_we_o, aw_ready_o, w_ready_o} !== 4'b1111) begin
            fails++;
            $display("FAIL late_w_grant: got req/we/awr/wr=%b, required 1111",
                     {mem_req_o, mem_we_o, aw_ready_o, w_ready_o});
        end
        step();
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (wr_count - w0 !== 1) begin
            fails++;
            $display("FAIL single_write: got %0d writes, required 1", wr_count - w0);
        end
        for (int i = 0; i < 10 && exp_b.size() != 0; i++) step();
        tests++;
        if (exp_b.size() != 0) begin
            fails++;
            $display("FAIL b_timeout: got %0d pending, required 0", exp_b.size());
            exp_b.delete();
        end
    endtask

    task automatic test_read();
        ar_valid_i = 1'b1; ar_addr_i = 32'h10; ar_id_i = 4'd5;
        exp_r.push_back({4'd5, 32'hDEADBEEF, 2'b00});
        @(negedge clk_i);
        tests++;
        if ({mem_req_o, mem_we_o, ar_ready_o, aw_ready_o} !== 4'b1010 || mem_addr_o !== 32'h10 || mem_strb_o !== 4'hF) begin
            fails++;
            $display("FAIL read_grant: got req/we/arr/awr=%b addr=%h strb=%h, required 1010 10 f",
                     {mem_req_o, mem_we_o, ar_ready_o, aw_ready_o}, mem_addr_o, mem_strb_o);
        end
        step();
        ar_valid_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (r_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL r_early: got r_valid=%b one cycle after AR, required 0", r_valid_o);
        end
        step();
        @(negedge clk_i);
        tests++;
        if (r_valid_o !== 1'b1) begin
            fails++;
            $display("FAIL r_latency: got r_valid=%b two cycles after AR, required 1", r_valid_o);
        end
        step();
        ar_valid_i = 1'b1; ar_addr_i = 32'h20; ar_id_i = 4'd2;
        exp_r.push_back({4'd2, 32'h00005678, 2'b00});
        @(negedge clk_i);
        tests++;
        if (ar_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL read2_grant: got ar_ready=%b, required 1", ar_ready_o);
        end
        step();
        ar_valid_i = 1'b0;
        for (int i = 0; i < 10 && exp_r.size() != 0; i++) step();
        tests++;
        if (exp_r.size() != 0) begin
            fails++;
            $display("FAIL r_timeout: got %0d pending, required 0", exp_r.size());
            exp_r.delete();
        end
    endtask

    task automatic test_read_credits();
        r_ready_i = 1'b0;
        ar_valid_i = 1'b1; ar_addr_i = 32'h10;
        for (int i = 1; i <= 2; i++) begin
            ar_id_i = 4'(i);
            @(negedge clk_i);
            tests++;
            if (ar_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL credit_grant %0d: got ar_ready=%b, required 1", i, ar_ready_o);
            end
            exp_r.push_back({4'(i), 32'hDEADBEEF, 2'b00});
            step();
        end
        ar_id_i = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            tests++;
            if ({ar_ready_o, mem_req_o} !== 2'b00) begin
                fails++;
                $display("FAIL credit_block cycle %0d: got arr/req=%b, required 00", i, {ar_ready_o, mem_req_o});
            end
            step();
        end
        r_ready_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (ar_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL credit_pop_cycle: got ar_ready=%b, required 0", ar_ready_o);
        end
        step();
        @(negedge clk_i);
        tests++;
        if (ar_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL credit_restored: got ar_ready=%b, required 1", ar_ready_o);
        end
        exp_r.push_back({4'd3, 32'hDEADBEEF, 2'b00});
        step();
        ar_valid_i = 1'b0;
        for (int i = 0; i < 10 && exp_r.size() != 0; i++) step();
        tests++;
        if (exp_r.size() != 0) begin
            fails++;
            $display("FAIL credit_drain: got %0d pending, required 0", exp_r.size());
            exp_r.delete();
        end
    endtask

    task automatic test_alternate();
        logic [31:0] wa [4];
        logic [31:0] wd [4];
        logic [3:0]  wid [4];
        logic [31:0] ra [4];
        logic [3:0]  rid [4];
        logic [31:0] rd [4];
        logic [1:0]  rr [4];
        logic        exp_we;
        int wi = 0;
        int ri = 0;
        wa  = '{32'h40, 32'h44, 32'h48, 32'h4C};
        wd  = '{32'hA5A50001, 32'h0BADF00D, 32'h13579BDF, 32'h0};
        wid = '{4'd8, 4'd9, 4'd10, 4'd15};
        ra  = '{32'h10, 32'hBAD0, 32'h40, 32'h10};
        rid = '{4'd4, 4'd6, 4'd11, 4'd14};
        rd  = '{32'hDEADBEEF, 32'h0, 32'hA5A50001, 32'hDEADBEEF};
        rr  = '{2'b00, 2'b10, 2'b00, 2'b00};
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1; w_strb_i = 4'hF;
        aw_addr_i = wa[0]; w_data_i = wd[0]; aw_id_i = wid[0];
        ar_addr_i = ra[0]; ar_id_i = rid[0];
        for (int k = 0; k < 6; k++) begin
            exp_we = (k % 2 == 0);
            @(negedge clk_i);
            tests++;
            if ({mem_req_o, mem_we_o, aw_ready_o, w_ready_o, ar_ready_o} !== {1'b1, exp_we, exp_we, exp_we, !exp_we}) begin
                fails++;
                $display("FAIL grant_order k=%0d: got req/we/awr/wr/arr=%b, required %b", k,
                         {mem_req_o, mem_we_o, aw_ready_o, w_ready_o, ar_ready_o},
                         {1'b1, exp_we, exp_we, exp_we, !exp_we});
            end
            if (exp_we) exp_b.push_back(wid[wi]);
            else        exp_r.push_back({rid[ri], rd[ri], rr[ri]});
            step();
            if (exp_we) begin
                wi++;
                aw_addr_i = wa[wi]; w_data_i = wd[wi]; aw_id_i = wid[wi];
            end else begin
                ri++;
                ar_addr_i = ra[ri]; ar_id_i = rid[ri];
            end
        end
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        for (int i = 0; i < 10 && (exp_r.size() != 0 || exp_b.size() != 0); i++) step();
        tests++;
        if (exp_r.size() != 0 || exp_b.size() != 0) begin
            fails++;
            $display("FAIL alternate_drain: got r=%0d b=%0d pending, required 0", exp_r.size(), exp_b.size());
            exp_r.delete();
            exp_b.delete();
        end
    endtask

    task automatic test_reset_mid();
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; aw_addr_i = 32'h60; aw_id_i = 4'd1; w_data_i = 32'h1;
        step();
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        ar_valid_i = 1'b1; ar_addr_i = 32'h10; ar_id_i = 4'd12;
        step();
        ar_id_i = 4'd13;
        step();
        ar_valid_i = 1'b0;
        step();
        step();
        @(negedge clk_i);
        tests++;
        if ({b_valid_o, r_valid_o} !== 2'b11) begin
            fails++;
            $display("FAIL mid_setup: got b_valid/r_valid=%b, required 11", {b_valid_o, r_valid_o});
        end
        #2;
        rst_i = 1'b1;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1; b_ready_i = 1'b1; r_ready_i = 1'b1;
        #1;
        tests++;
        if ({b_valid_o, r_valid_o, mem_req_o, aw_ready_o, w_ready_o, ar_ready_o} !== 6'b0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %b, required 000000",
                     {b_valid_o, r_valid_o, mem_req_o, aw_ready_o, w_ready_o, ar_ready_o});
        end
        exp_b.delete();
        exp_r.delete();
        step();
        step();
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        rst_i = 1'b0;
        r_ready_i = 1'b0;
        step();
        ar_valid_i = 1'b1; ar_addr_i = 32'h10;
        for (int i = 1; i <= 3; i++) begin
            ar_id_i = 4'(i);
            @(negedge clk_i);
            tests++;
            if (ar_ready_o !== (i <= 2)) begin
                fails++;
                $display("FAIL post_reset_credit %0d: got ar_ready=%b, required %b", i, ar_ready_o, (i <= 2));
            end
            if (i <= 2) exp_r.push_back({4'(i), 32'hDEADBEEF, 2'b00});
            step();
        end
        ar_valid_i = 1'b0;
        tests++;
        if (b_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_b: got b_valid=%b, required 0", b_valid_o);
        end
        r_ready_i = 1'b1;
        for (int i = 0; i < 10 && exp_r.size() != 0; i++) step();
        tests++;
        if (exp_r.size() != 0) begin
            fails++;
            $display("FAIL post_reset_drain: got %0d pending, required 0", exp_r.size());
            exp_r.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_write_waits_for_w();
        test_read();
        test_read_credits();
        test_alternate();
        test_reset_mid();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
